// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the decode, issue and ALU stages: default field widths,
// field offsets, the decoded-field record and the decode buffer occupancy encoding.
package cpu_isa_pkg;

  localparam int OPCODE_W_DEF    = 4;
  localparam int REG_W_DEF       = 4;
  localparam int IMM_W_DEF       = 4;
  localparam int DATA_W_DEF      = 16;
  localparam int NUM_OPCODES_DEF = 12;

  // Bit offsets of each field inside an instruction of default geometry
  localparam int IMM_LSB_DEF    = 0;
  localparam int REG_B_LSB_DEF  = IMM_W_DEF;
  localparam int REG_A_LSB_DEF  = IMM_W_DEF + REG_W_DEF;
  localparam int OPCODE_LSB_DEF = IMM_W_DEF + 2 * REG_W_DEF;
  localparam int INSTR_W_DEF    = OPCODE_W_DEF + 2 * REG_W_DEF + IMM_W_DEF;

  typedef struct packed {
    logic [OPCODE_W_DEF-1:0] opcode;
    logic [REG_W_DEF-1:0]    reg_a;
    logic [REG_W_DEF-1:0]    reg_b;
    logic [DATA_W_DEF-1:0]   imm_ext;
    logic                    illegal;
  } instr_fields_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/instruction_decode_stage_if.sv
// Fetch-to-decode and decode-to-issue handshake bundle. The master drives words in and
// accepts decoded fields; the slave is the decode stage.
interface instruction_decode_stage_if
  import cpu_isa_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int REG_W    = REG_W_DEF,
  parameter int IMM_W    = IMM_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
);
  localparam int INSTR_W = OPCODE_W + 2 * REG_W + IMM_W;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instruction;
  logic               out_valid;
  logic               out_ready;
  logic [OPCODE_W-1:0] opcode;
  logic [REG_W-1:0]   reg_a;
  logic [REG_W-1:0]   reg_b;
  logic [DATA_W-1:0]  imm_ext;
  logic               illegal;

  modport master (
    output in_valid, instruction, out_ready,
    input  in_ready, out_valid, opcode, reg_a, reg_b, imm_ext, illegal
  );

  modport slave (
    input  in_valid, instruction, out_ready,
    output in_ready, out_valid, opcode, reg_a, reg_b, imm_ext, illegal
  );

endinterface

// File: rtl/decode_skid_buffer.sv
// Generic 2-entry valid/ready skid register: main entry drives the outputs, the skid
// entry absorbs one word when the consumer stalls. in_ready is a pure register.
module decode_skid_buffer
  import cpu_isa_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_t         occ_q, occ_d;
  logic         ready_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         accept, issue;
  logic         load_main_in, load_main_skid, load_skid;

  assign accept    = in_valid & ready_q & ~flush;
  assign issue     = (occ_q != OCC_EMPTY) & out_ready;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign in_ready  = ready_q;
  assign out_data  = main_q;

  always_comb begin
    occ_d          = occ_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            occ_d        = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && issue) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            occ_d     = OCC_TWO;
          end else if (issue) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // in_ready is low in this state, so only a drain can happen
          if (issue) begin
            load_main_skid = 1'b1;
            occ_d          = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q   <= OCC_EMPTY;
      ready_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      ready_q <= (occ_d != OCC_TWO);
    end
  end

  // Stage 1: main entry, reset so the outputs read zero out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
    end else if (load_main_in) begin
      main_q <= in_data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_q <= in_data;
    end
  end

  a_occ_legal: assert property (@(posedge clk) disable iff (!reset_n)
    occ_q inside {OCC_EMPTY, OCC_ONE, OCC_TWO});

endmodule

// File: rtl/instruction_decode_stage.sv
// Registered decode stage: splits the instruction into fields, extends the immediate and
// flags illegal opcodes at accept, then buffers the decoded record in a 2-entry skid.
module instruction_decode_stage
  import cpu_isa_pkg::*;
#(
  parameter int OPCODE_W    = OPCODE_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int IMM_W       = IMM_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int IMM_SIGNED  = 1,
  parameter int NUM_OPCODES = NUM_OPCODES_DEF,
  parameter int COUNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  instruction_decode_stage_if.slave  bus,
  output logic [COUNT_W-1:0]         decode_count
);

  localparam int IMM_LSB    = 0;
  localparam int REG_B_LSB  = IMM_W;
  localparam int REG_A_LSB  = IMM_W + REG_W;
  localparam int OPCODE_LSB = IMM_W + 2 * REG_W;
  localparam int PAY_W      = OPCODE_W + 2 * REG_W + DATA_W + 1;

  if (DATA_W < IMM_W) begin : g_bad_data_w
    $error("instruction_decode_stage: DATA_W must be >= IMM_W");
  end
  if (NUM_OPCODES < 1 || NUM_OPCODES > (2 ** OPCODE_W)) begin : g_bad_num_opcodes
    $error("instruction_decode_stage: NUM_OPCODES must be in 1..2**OPCODE_W");
  end

  function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm);
    logic [DATA_W-1:0] r;
    r = {DATA_W{(IMM_SIGNED != 0) ? imm[IMM_W-1] : 1'b0}};
    r[IMM_W-1:0] = imm;
    return r;
  endfunction

  logic [OPCODE_W-1:0] opcode_p0;
  logic [REG_W-1:0]    reg_a_p0;
  logic [REG_W-1:0]    reg_b_p0;
  logic [DATA_W-1:0]   imm_ext_p0;
  logic                illegal_p0;
  logic [PAY_W-1:0]    pay_p0;
  logic [PAY_W-1:0]    pay_p1;
  logic                vld_p1;
  logic [COUNT_W-1:0]  count_q;

  // Stage 0: combinational field split ahead of the buffer
  assign opcode_p0  = bus.instruction[OPCODE_LSB +: OPCODE_W];
  assign reg_a_p0   = bus.instruction[REG_A_LSB +: REG_W];
  assign reg_b_p0   = bus.instruction[REG_B_LSB +: REG_W];
  assign imm_ext_p0 = extend_imm(bus.instruction[IMM_LSB +: IMM_W]);
  assign illegal_p0 = (32'(opcode_p0) >= 32'(NUM_OPCODES));
  assign pay_p0     = {opcode_p0, reg_a_p0, reg_b_p0, imm_ext_p0, illegal_p0};

  decode_skid_buffer #(
    .W(PAY_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (pay_p0),
    .out_valid (vld_p1),
    .out_ready (bus.out_ready),
    .out_data  (pay_p1)
  );

  // Stage 1: registered decoded record drives the issue side
  assign bus.out_valid = vld_p1;
  assign {bus.opcode, bus.reg_a, bus.reg_b, bus.imm_ext, bus.illegal} = pay_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (vld_p1 && bus.out_ready) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign decode_count = count_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: two instances (signed 16-bit and unsigned 8-bit
// immediates, 4-bit counter) share one stimulus and are checked against a queue model.
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] instr;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl_q[$];
  logic        mdl_ready;
  int          mdl_cnt;

  always #5 clk = ~clk;

  instruction_decode_stage_if #(.OPCODE_W(4), .REG_W(4), .IMM_W(4), .DATA_W(16)) ifa ();
  instruction_decode_stage_if #(.OPCODE_W(4), .REG_W(4), .IMM_W(4), .DATA_W(8))  ifb ();

  assign ifa.in_valid = in_valid;
  assign ifa.instruction = instr;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid = in_valid;
  assign ifb.instruction = instr;
  assign ifb.out_ready = out_ready;

  instruction_decode_stage #(.DATA_W(16), .IMM_SIGNED(1), .COUNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(ifa.slave), .decode_count(cnt_a));

  instruction_decode_stage #(.DATA_W(8), .IMM_SIGNED(0), .COUNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(ifb.slave), .decode_count(cnt_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of at most two accepted words, front is what is on the outputs
  always @(negedge reset_n) begin
    mdl_q.delete();
    mdl_ready = 1'b0;
    mdl_cnt   = 0;
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      mdl_q.delete();
      mdl_ready = 1'b0;
      mdl_cnt   = 0;
    end else if (flush) begin
      mdl_q.delete();
      mdl_ready = 1'b1;
    end else begin
      logic iss, acc;
      iss = (mdl_q.size() > 0) && out_ready;
      acc = in_valid && mdl_ready;
      if (iss) begin
        void'(mdl_q.pop_front());
        mdl_cnt++;
      end
      if (acc) mdl_q.push_back(instr);
      mdl_ready = (mdl_q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      logic [15:0] w;
      chk("in_ready_a", 32'(ifa.in_ready), 32'(mdl_ready));
      chk("in_ready_b", 32'(ifb.in_ready), 32'(mdl_ready));
      chk("out_valid_a", 32'(ifa.out_valid), 32'(mdl_q.size() != 0));
      chk("out_valid_b", 32'(ifb.out_valid), 32'(mdl_q.size() != 0));
      chk("count_a", 32'(cnt_a), mdl_cnt % 65536);
      chk("count_b", 32'(cnt_b), mdl_cnt % 16);
      if (mdl_q.size() != 0) begin
        w = mdl_q[0];
        chk("opcode_a", 32'(ifa.opcode), 32'(w[15:12]));
        chk("reg_a_a", 32'(ifa.reg_a), 32'(w[11:8]));
        chk("reg_b_a", 32'(ifa.reg_b), 32'(w[7:4]));
        chk("imm_a", 32'(ifa.imm_ext), 32'($signed(w[3:0])) & 32'hFFFF);
        chk("illegal_a", 32'(ifa.illegal), 32'(w[15:12] >= 4'd12));
        chk("opcode_b", 32'(ifb.opcode), 32'(w[15:12]));
        chk("imm_b", 32'(ifb.imm_ext), 32'(w[3:0]));
        chk("illegal_b", 32'(ifb.illegal), 32'(w[15:12] >= 4'd12));
      end
    end
  end

  a_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (ifa.out_valid && !ifa.out_ready && !flush) |=>
      (ifa.out_valid && $stable({ifa.opcode, ifa.reg_a, ifa.reg_b, ifa.imm_ext, ifa.illegal})))
    else begin
      errors++;
      $display("FAIL hold_stable: fields changed while stalled at %0t", $time);
    end

  initial begin
    logic [15:0] saved;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    #1;
    chk("rst_out_valid", 32'(ifa.out_valid), 0);
    chk("rst_in_ready", 32'(ifa.in_ready), 0);
    chk("rst_imm", 32'(ifa.imm_ext), 0);
    chk("rst_count", 32'(cnt_a), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(ifa.in_ready), 1);

    // Streaming decode, one word per cycle
    out_ready = 1'b1; in_valid = 1'b1; instr = 16'h1234;
    tick();
    chk("t1_op0", 32'(ifa.opcode), 32'h1);
    chk("t1_ra0", 32'(ifa.reg_a), 32'h2);
    chk("t1_rb0", 32'(ifa.reg_b), 32'h3);
    chk("t1_imm0", 32'(ifa.imm_ext), 32'h0004);
    instr = 16'h5A3F;
    tick();
    chk("t1_op1", 32'(ifa.opcode), 32'h5);
    chk("t1_ra1", 32'(ifa.reg_a), 32'hA);
    chk("t1_imm1", 32'(ifa.imm_ext), 32'hFFFF);
    chk("t1_ill1", 32'(ifa.illegal), 0);
    instr = 16'hC000;
    tick();
    chk("t1_op2", 32'(ifa.opcode), 32'hC);
    chk("t1_ill2", 32'(ifa.illegal), 1);
    chk("t1_vld2", 32'(ifa.out_valid), 1);
    in_valid = 1'b0;
    tick();
    chk("t1_count", 32'(cnt_a), 3);

    // Unsigned 8-bit immediate
    in_valid = 1'b1; instr = 16'h7128;
    tick();
    chk("t3_imm_b8", 32'(ifb.imm_ext), 32'h08);
    instr = 16'h712F;
    tick();
    chk("t3_imm_bF", 32'(ifb.imm_ext), 32'h0F);
    chk("t3_imm_aF", 32'(ifa.imm_ext), 32'hFFFF);
    in_valid = 1'b0;
    tick();

    // Backpressure fills main and skid, third word is held off
    out_ready = 1'b0; in_valid = 1'b1; instr = 16'h2111;
    tick();
    instr = 16'h3222;
    tick();
    instr = 16'h4333;
    tick(); tick();
    chk("t2_ready_low", 32'(ifa.in_ready), 0);
    chk("t2_hold_op", 32'(ifa.opcode), 32'h2);
    out_ready = 1'b1;
    tick();
    chk("t2_op_w2", 32'(ifa.opcode), 32'h3);
    tick();
    chk("t2_op_w3", 32'(ifa.opcode), 32'h4);
    in_valid = 1'b0;
    tick();
    chk("t2_drained", 32'(ifa.out_valid), 0);

    // Flush with both entries full and a word offered
    saved = cnt_a;
    out_ready = 1'b0; in_valid = 1'b1; instr = 16'h6444;
    tick();
    instr = 16'h6555;
    tick();
    instr = 16'h6666; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_vld", 32'(ifa.out_valid), 0);
    chk("t4_ready", 32'(ifa.in_ready), 1);
    out_ready = 1'b1;
    tick(); tick();
    chk("t4_still_empty", 32'(ifa.out_valid), 0);
    chk("t4_count", 32'(cnt_a), 32'(saved));

    // Asynchronous reset between edges
    in_valid = 1'b1; instr = 16'h3A5C;
    tick(); tick();
    #3 reset_n = 1'b0;
    #1;
    chk("t5_vld", 32'(ifa.out_valid), 0);
    chk("t5_op", 32'(ifa.opcode), 0);
    chk("t5_imm", 32'(ifa.imm_ext), 0);
    chk("t5_cnt", 32'(cnt_a), 0);
    chk("t5_ready", 32'(ifa.in_ready), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    chk("t5_ready_up", 32'(ifa.in_ready), 1);
    chk("t5_cnt_zero", 32'(cnt_a), 0);

    // Counter wrap on the 4-bit instance
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      instr = 16'(i * 16'h0111);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("t6_cnt_b_wrap", 32'(cnt_b), 1);
    chk("t6_cnt_a", 32'(cnt_a), 17);

    // Random valid/ready/flush traffic
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = 16'($urandom);
      flush     = !out_ready && ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
